// File: rtl/track_sequencer.sv
// track_sequencer: record/playback address sequencer for the note memory.
//
// main_mem is divided into five fixed slots of SLOT_LEN words, slot k
// starting at k*SLOT_LEN, one slot per track button. In record mode every
// player tick writes one word into the selected slot. In play mode every
// tick steps the read address through the recorded part of the slot.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   tick        one-clk note-step enable from the player clock divider
//   btn[4:0]    track buttons {b5..b1}, debounced levels
//   sw_rec      record-mode switch (1 = record)
//   mem_addr    registered main_mem address
//   mem_we      registered main_mem write enable (REC only)
//   rec_active  high while recording
//   play_active high while playing
//   cur_slot    selected slot index 0..4
//   slot_full   one-clk pulse when a recording stops at SLOT_LEN words
//
// Build option: define TRACK_LOOP_EN to make playback loop over the track
// indefinitely; otherwise playback stops after the last recorded word.

module track_sequencer #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned SLOT_LEN = 800,
    parameter int unsigned LEN_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [4:0]        btn,
    input  logic              sw_rec,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              rec_active,
    output logic              play_active,
    output logic [2:0]        cur_slot,
    output logic              slot_full
);

    typedef enum logic [1:0] {IDLE, REC, PLAY} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  offset_q, offset_d;
    logic [LEN_W-1:0]  len_q [5];
    logic [LEN_W-1:0]  len_d [5];
    logic [4:0]        btn_q;
    logic [2:0]        slot_q, slot_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              full_q, full_d;

    // Press decode: rising edges only, lowest index wins, the rest are dropped.
    logic [4:0]        rise;
    logic              press;
    logic [2:0]        press_idx;
    logic              press_on_cur;
    logic [LEN_W-1:0]  press_len;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  offset_inc;
    logic [LEN_W-1:0]  rec_len;
    logic [ADDR_W-1:0] step_addr;

    always_comb begin
        rise      = btn & ~btn_q;
        press     = 1'b0;
        press_idx = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            if (rise[k] && !press) begin
                press     = 1'b1;
                press_idx = 3'(k);
            end
        end
        press_on_cur = press && (press_idx == slot_q);
        press_len    = len_q[press_idx];
        cur_len      = len_q[slot_q];
        offset_inc   = offset_q + LEN_W'(1);
        step_addr    = ADDR_W'(slot_q) * ADDR_W'(SLOT_LEN) + ADDR_W'(offset_q);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            offset_q <= '0;
            btn_q    <= '0;
            slot_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            full_q   <= 1'b0;
            for (int unsigned k = 0; k < 5; k++) begin
                len_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            btn_q    <= btn;
            slot_q   <= slot_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            full_q   <= full_d;
            for (int unsigned k = 0; k < 5; k++) begin
                len_q[k] <= len_d[k];
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        slot_d   = slot_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        full_d   = 1'b0;
        rec_len  = offset_q;
        for (int unsigned k = 0; k < 5; k++) begin
            len_d[k] = len_q[k];
        end

        case (state_q)
            IDLE: begin
                if (press) begin
                    if (sw_rec) begin
                        state_d  = REC;
                        slot_d   = press_idx;
                        offset_d = '0;
                    end else if (press_len != '0) begin
                        state_d  = PLAY;
                        slot_d   = press_idx;
                        offset_d = '0;
                    end
                end
            end

            REC: begin
                // A tick in the stopping cycle still writes and is counted.
                if (tick) begin
                    addr_d   = step_addr;
                    we_d     = 1'b1;
                    offset_d = offset_inc;
                    rec_len  = offset_inc;
                end
                if ((tick && offset_q == LEN_W'(SLOT_LEN - 1)) || !sw_rec || press_on_cur) begin
                    full_d   = tick && (offset_q == LEN_W'(SLOT_LEN - 1));
                    state_d  = IDLE;
                    offset_d = '0;
                    for (int unsigned k = 0; k < 5; k++) begin
                        if (3'(k) == slot_q) begin
                            len_d[k] = rec_len;
                        end
                    end
                end
            end

            PLAY: begin
                if (press_on_cur) begin
                    state_d  = IDLE;
                    offset_d = '0;
                end else if (press && press_len != '0) begin
                    slot_d   = press_idx;
                    offset_d = '0;
                end else if (tick) begin
                    addr_d = step_addr;
                    if (offset_q == cur_len - LEN_W'(1)) begin
                        offset_d = '0;
`ifndef TRACK_LOOP_EN
                        state_d  = IDLE;
`endif
                    end else begin
                        offset_d = offset_inc;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        mem_addr    = addr_q;
        mem_we      = we_q;
        rec_active  = (state_q == REC);
        play_active = (state_q == PLAY);
        cur_slot    = slot_q;
        slot_full   = full_q;
    end

endmodule

// File: tb/tb_track_sequencer.sv
`timescale 1ns/1ps

module tb_track_sequencer;

    localparam int ADDR_W   = 12;
    localparam int SLOT_LEN = 800;
    localparam int LEN_W    = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick;
    logic [4:0]        btn;
    logic              sw_rec;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              rec_active;
    logic              play_active;
    logic [2:0]        cur_slot;
    logic              slot_full;

    int checks = 0;
    int errors = 0;
    int lens [5];   // reference model: recorded length of each slot

    track_sequencer #(.ADDR_W(ADDR_W), .SLOT_LEN(SLOT_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btn(btn), .sw_rec(sw_rec),
        .mem_addr(mem_addr), .mem_we(mem_we), .rec_active(rec_active),
        .play_active(play_active), .cur_slot(cur_slot), .slot_full(slot_full)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic press(input logic [4:0] m);
        btn = m;
        @(negedge clk);
        btn = '0;
        @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        checks++; if (rec_active !== 1'b0) begin errors++; $display("FAIL reset_rec: got %b expected 0", rec_active); end
        checks++; if (play_active !== 1'b0) begin errors++; $display("FAIL reset_play: got %b expected 0", play_active); end
        checks++; if (cur_slot !== 3'd0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", cur_slot); end
        checks++; if (slot_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", slot_full); end
    endtask

    // Record n ticks into slot; optionally drop sw_rec in the same cycle as the last tick.
    task automatic test_record(input int slot, input int n, input bit coincide);
        logic [4:0] m;
        int base;
        m = '0; m[slot] = 1'b1;
        base = slot * SLOT_LEN;
        sw_rec = 1'b1;
        press(m);
        checks++; if (rec_active !== 1'b1) begin errors++; $display("FAIL rec_start: got %b expected 1", rec_active); end
        checks++; if (cur_slot !== 3'(slot)) begin errors++; $display("FAIL rec_slot: got %0d expected %0d", cur_slot, slot); end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (coincide && i == n - 1) sw_rec = 1'b0;
            do_tick();
            checks++; if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(base + i)) begin
                errors++; $display("FAIL rec_write: got we=%b addr=%0d expected we=1 addr=%0d", mem_we, mem_addr, base + i);
            end
        end
        sw_rec = 1'b0;
        @(negedge clk);
        checks++; if (rec_active !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rec_stop: got rec=%b we=%b expected rec=0 we=0", rec_active, mem_we);
        end
        lens[slot] = n;
    endtask

    task automatic test_play(input int slot, input int nt);
        logic [4:0] m;
        int L, base, expa, last;
        bit playing;
        m = '0; m[slot] = 1'b1;
        L = lens[slot];
        base = slot * SLOT_LEN;
        sw_rec = 1'b0;
        press(m);
        if (L == 0) begin
            checks++; if (play_active !== 1'b0) begin errors++; $display("FAIL play_empty: got %b expected 0", play_active); end
            return;
        end
        checks++; if (play_active !== 1'b1 || cur_slot !== 3'(slot)) begin
            errors++; $display("FAIL play_start: got play=%b slot=%0d expected play=1 slot=%0d", play_active, cur_slot, slot);
        end
        sw_rec = 1'b1;
        @(negedge clk);
        sw_rec = 1'b0;
        checks++; if (play_active !== 1'b1 || rec_active !== 1'b0) begin
            errors++; $display("FAIL play_swrec: got play=%b rec=%b expected play=1 rec=0", play_active, rec_active);
        end
        playing = 1'b1;
        last = 0;
        for (int i = 0; i < nt && playing; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_tick();
            expa = base + (i % L);
            checks++; if (mem_addr !== ADDR_W'(expa) || mem_we !== 1'b0) begin
                errors++; $display("FAIL play_addr: got addr=%0d we=%b expected addr=%0d we=0", mem_addr, mem_we, expa);
            end
`ifndef TRACK_LOOP_EN
            if (i == L - 1) playing = 1'b0;
`endif
            checks++; if (play_active !== playing) begin
                errors++; $display("FAIL play_active: got %b expected %b", play_active, playing);
            end
            last = expa;
        end
        if (playing) begin
            press(m);
            checks++; if (play_active !== 1'b0) begin errors++; $display("FAIL play_stop: got %b expected 0", play_active); end
        end
        @(negedge clk);
        checks++; if (mem_addr !== ADDR_W'(last)) begin
            errors++; $display("FAIL idle_hold: got %0d expected %0d", mem_addr, last);
        end
    endtask

    task automatic test_reset_mid();
        sw_rec = 1'b1;
        press(5'b01000);
        do_tick();
        do_tick();
        @(negedge clk);
        tick = 1'b1;
        #2 reset = 1'b0;
        #1;
        test_reset();
        tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) lens[k] = 0;
        sw_rec = 1'b0;
        @(negedge clk);
        press(5'b01000);
        checks++; if (play_active !== 1'b0) begin errors++; $display("FAIL reset_len_lost: got play=%b expected 0", play_active); end
    endtask

    task automatic test_arbitration();
        sw_rec = 1'b1;
        press(5'b10100);
        checks++; if (cur_slot !== 3'd2 || rec_active !== 1'b1) begin
            errors++; $display("FAIL arb_lowest: got slot=%0d rec=%b expected slot=2 rec=1", cur_slot, rec_active);
        end
        press(5'b00001);
        checks++; if (cur_slot !== 3'd2 || rec_active !== 1'b1) begin
            errors++; $display("FAIL arb_rec_other: got slot=%0d rec=%b expected slot=2 rec=1", cur_slot, rec_active);
        end
        for (int i = 0; i < 2; i++) begin
            do_tick();
            checks++; if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(2 * SLOT_LEN + i)) begin
                errors++; $display("FAIL arb_write: got we=%b addr=%0d expected we=1 addr=%0d", mem_we, mem_addr, 2 * SLOT_LEN + i);
            end
        end
        press(5'b00100);
        checks++; if (rec_active !== 1'b0) begin errors++; $display("FAIL arb_stop_cur: got rec=%b expected 0", rec_active); end
        lens[2] = 2;
        sw_rec = 1'b0;
        @(negedge clk);
        press(5'b00010);
        do_tick();
        checks++; if (mem_addr !== ADDR_W'(SLOT_LEN)) begin errors++; $display("FAIL arb_play1: got %0d expected %0d", mem_addr, SLOT_LEN); end
        press(5'b00001);
        checks++; if (play_active !== 1'b1 || cur_slot !== 3'd1) begin
            errors++; $display("FAIL arb_play_empty: got play=%b slot=%0d expected play=1 slot=1", play_active, cur_slot);
        end
        press(5'b00100);
        checks++; if (play_active !== 1'b1 || cur_slot !== 3'd2) begin
            errors++; $display("FAIL arb_switch: got play=%b slot=%0d expected play=1 slot=2", play_active, cur_slot);
        end
        do_tick();
        checks++; if (mem_addr !== ADDR_W'(2 * SLOT_LEN)) begin errors++; $display("FAIL arb_switch_addr: got %0d expected %0d", mem_addr, 2 * SLOT_LEN); end
        if (play_active) press(5'b00100);
        checks++; if (play_active !== 1'b0) begin errors++; $display("FAIL arb_stop_play: got %b expected 0", play_active); end
    endtask

    task automatic test_full();
        sw_rec = 1'b1;
        press(5'b00001);
        for (int i = 0; i < SLOT_LEN + 2; i++) begin
            do_tick();
            if (i < SLOT_LEN) begin
                checks++; if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(i)) begin
                    errors++; $display("FAIL full_write: got we=%b addr=%0d expected we=1 addr=%0d", mem_we, mem_addr, i);
                end
            end else begin
                checks++; if (mem_we !== 1'b0 || mem_addr !== ADDR_W'(SLOT_LEN - 1)) begin
                    errors++; $display("FAIL full_after: got we=%b addr=%0d expected we=0 addr=%0d", mem_we, mem_addr, SLOT_LEN - 1);
                end
            end
            checks++; if (slot_full !== (i == SLOT_LEN - 1)) begin
                errors++; $display("FAIL full_pulse: got %b expected %b at tick %0d", slot_full, (i == SLOT_LEN - 1), i);
            end
            if (i == SLOT_LEN - 1) begin
                checks++; if (rec_active !== 1'b0) begin errors++; $display("FAIL full_rec: got %b expected 0", rec_active); end
            end
        end
        sw_rec = 1'b0;
        @(negedge clk);
        lens[0] = SLOT_LEN;
        test_play(0, 3);
    endtask

    task automatic test_random();
        int slot, n;
        for (int it = 0; it < 10; it++) begin
            slot = $urandom_range(0, 4);
            n = $urandom_range(1, 12);
            test_record(slot, n, 1'($urandom_range(0, 1)));
            test_play(slot, $urandom_range(1, 2 * n + 2));
            test_play($urandom_range(0, 4), $urandom_range(1, 6));
        end
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; btn = '0; sw_rec = 1'b0;
        for (int k = 0; k < 5; k++) lens[k] = 0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_record(1, 3, 1'b0);
        test_play(1, 7);
        test_reset_mid();
        test_record(1, 3, 1'b0);
        test_arbitration();
        test_full();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
